// File: rtl/ads1256_sampler.sv
// ADS1256 RDATA sequencer driving a byte-wide SPI core; owns chip select and assembles 24-bit samples.
// Frame = CS_SETUP + cmd byte + T6_CYCLES + 3 read bytes + CS_HOLD; sample_valid_o pulses 1 cycle after the 3rd byte.
module ads1256_sampler #(
  parameter int T6_CYCLES = 700,
  parameter int CS_SETUP  = 4,
  parameter int CS_HOLD   = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        start_i,
  input  logic        drdy_n_i,
  output logic        spi_start_o,
  output logic [7:0]  spi_tx_o,
  input  logic [7:0]  spi_rx_i,
  input  logic        spi_done_i,
  output logic        cs_n_o,
  output logic [23:0] sample_o,
  output logic        sample_valid_o,
  output logic        busy_o
);

  localparam int CW = $clog2(T6_CYCLES + CS_SETUP + CS_HOLD + 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] T6_LAST    = CW'(T6_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_DRDY, CS_SET, CMD_WAIT, T6, RD_WAIT, HOLD
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    k, k_nxt;
  logic [15:0]   shift, shift_nxt;
  logic          pending, pending_nxt;
  logic          start_nxt, cs_n_nxt, busy_nxt, valid_nxt;
  logic [7:0]    tx_nxt;
  logic [23:0]   sample_nxt;
  logic          drdy_meta, drdy_s, armed;

  // armed blocks a second read of the same conversion while DRDY stays low
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      drdy_meta <= 1'b1;
      drdy_s    <= 1'b1;
      armed     <= 1'b1;
    end else begin
      drdy_meta <= drdy_n_i;
      drdy_s    <= drdy_meta;
      if (sample_valid_o)
        armed <= 1'b0;
      else if (drdy_s)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      cnt            <= '0;
      k              <= 2'd0;
      shift          <= 16'h0000;
      pending        <= 1'b0;
      spi_start_o    <= 1'b0;
      spi_tx_o       <= 8'h00;
      cs_n_o         <= 1'b1;
      busy_o         <= 1'b0;
      sample_o       <= 24'h000000;
      sample_valid_o <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      k              <= k_nxt;
      shift          <= shift_nxt;
      pending        <= pending_nxt;
      spi_start_o    <= start_nxt;
      spi_tx_o       <= tx_nxt;
      cs_n_o         <= cs_n_nxt;
      busy_o         <= busy_nxt;
      sample_o       <= sample_nxt;
      sample_valid_o <= valid_nxt;
    end
  end

  // T6 and HOLD are timed from a spi_done_i cycle, so their counters start at 1
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    k_nxt       = k;
    shift_nxt   = shift;
    pending_nxt = pending;
    start_nxt   = 1'b0;
    tx_nxt      = spi_tx_o;
    cs_n_nxt    = cs_n_o;
    busy_nxt    = busy_o;
    sample_nxt  = sample_o;
    valid_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (enable_i || start_i) begin
          state_nxt   = WAIT_DRDY;
          pending_nxt = start_i;
        end
      end
      WAIT_DRDY: begin
        if (start_i)
          pending_nxt = 1'b1;
        if (!drdy_s && armed) begin
          state_nxt = CS_SET;
          cnt_nxt   = '0;
          cs_n_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end else if (!enable_i && !pending && !start_i) begin
          state_nxt = IDLE;
        end
      end
      CS_SET: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = CMD_WAIT;
          start_nxt = 1'b1;
          tx_nxt    = 8'h01;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      CMD_WAIT: begin
        if (spi_done_i) begin
          state_nxt = T6;
          cnt_nxt   = CNT_ONE;
        end
      end
      T6: begin
        if (cnt == T6_LAST) begin
          state_nxt = RD_WAIT;
          start_nxt = 1'b1;
          tx_nxt    = 8'h00;
          k_nxt     = 2'd0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RD_WAIT: begin
        if (spi_done_i) begin
          shift_nxt = {shift[7:0], spi_rx_i};
          if (k == 2'd2) begin
            state_nxt  = HOLD;
            cnt_nxt    = CNT_ONE;
            sample_nxt = {shift, spi_rx_i};
            valid_nxt  = 1'b1;
          end else begin
            k_nxt     = k + 2'd1;
            start_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          cs_n_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          pending_nxt = 1'b0;
          state_nxt   = enable_i ? WAIT_DRDY : IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
